// File: rtl/conv_encoder_tx_pkg.sv
// Shared constants and types for the rate-1/2, K=9 convolutional encoder.
// The decoder trellis uses the same values, so the two cannot drift apart.
package conv_encoder_tx_pkg;
  localparam int K        = 9;
  localparam int WD_STATE = K - 1;
  localparam int WD_LEN   = 12;
  localparam int WD_TCNT  = $clog2(K);

  localparam logic [K-1:0]       POLY0     = 9'o753;
  localparam logic [K-1:0]       POLY1     = 9'o561;
  localparam logic [WD_TCNT-1:0] TAIL_LAST = WD_TCNT'(K - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;
endpackage

// File: rtl/conv_encoder_tx_parity.sv
// Combinational parity of {u,s} against the two generator polynomials.
// Bit K-1 of i_word is the current bit u; lower bits are the shift register.
module conv_parity #(
  parameter int           K     = 9,
  parameter logic [K-1:0] POLY0 = 9'o753,
  parameter logic [K-1:0] POLY1 = 9'o561
) (
  input  logic [K-1:0] i_word,
  output logic [1:0]   o_sym
);
  assign o_sym = {^(i_word & POLY1), ^(i_word & POLY0)};
endmodule

// File: rtl/conv_encoder_tx.sv
// Bit-serial rate-1/2 convolutional encoder with zero-tail termination,
// valid/ready on both sides and a single-entry output register.
module conv_encoder_tx
  import conv_encoder_tx_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [WD_LEN-1:0] i_frame_len,
  input  logic              i_in_valid,
  input  logic              i_in_bit,
  output logic              o_in_ready,
  output logic              o_out_valid,
  output logic [1:0]        o_out_symbol,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_busy
);
  state_t              r_state, w_state_nxt;
  logic [WD_STATE-1:0] r_shift;
  logic [WD_LEN-1:0]   r_bit_cnt;
  logic [WD_TCNT-1:0]  r_tail_cnt;
  logic                r_out_valid, r_out_last;
  logic [1:0]          r_out_sym;

  logic       w_advance, w_start_ok, w_load, w_u;
  logic [1:0] w_sym;

  assign w_advance  = !r_out_valid || i_out_ready;
  // Start is only honoured once the previous frame's last symbol has drained.
  assign w_start_ok = i_start && (r_state == IDLE) && !r_out_valid;

  conv_parity #(.K(K), .POLY0(POLY0), .POLY1(POLY1)) u_parity (
    .i_word ({w_u, r_shift}),
    .o_sym  (w_sym)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_u         = 1'b0;
    o_in_ready  = 1'b0;
    case (r_state)
      IDLE: if (w_start_ok) w_state_nxt = (i_frame_len == '0) ? TAIL : DATA;
      DATA: begin
        o_in_ready = w_advance;
        w_u        = i_in_bit;
        w_load     = w_advance && i_in_valid;
        if (w_load && r_bit_cnt == WD_LEN'(1)) w_state_nxt = TAIL;
      end
      TAIL: begin
        w_load = w_advance;
        if (w_load && r_tail_cnt == TAIL_LAST) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_bit_cnt counts remaining information bits; r_tail_cnt counts tail symbols.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_tail_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_sym   <= '0;
    end else begin
      if (w_start_ok) r_bit_cnt <= i_frame_len;
      if (w_load) begin
        r_shift     <= {w_u, r_shift[WD_STATE-1:1]};
        r_out_sym   <= w_sym;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_state == TAIL) && (r_tail_cnt == TAIL_LAST);
        if (r_state == DATA) r_bit_cnt <= r_bit_cnt - 1'b1;
        if (r_state == TAIL)
          r_tail_cnt <= (r_tail_cnt == TAIL_LAST) ? '0 : r_tail_cnt + 1'b1;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_symbol = r_out_sym;
  assign o_out_last   = r_out_last;
  assign o_busy       = (r_state != IDLE) || r_out_valid;
endmodule
